// File: rtl/next_pc_unit.sv
// Fetch-side next-PC generator: direct-mapped BTB with 2-bit counters, same-cycle
// prediction from pc_i, EX-stage training, mispredict redirect/flush and a saturating mispredict count.
module next_pc_unit #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_branch_i,
    input  logic        ex_taken_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic [31:0] ex_pred_pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_write_o,
    output logic        pred_taken_o,
    output logic        flush_o,
    output logic [15:0] mispred_cnt_o
);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx, ex_idx;
    logic [TAG_W-1:0] lk_tag, ex_tag;
    logic             lk_hit, ex_hit, ex_br, mispredict;
    logic [31:0]      pred_next, actual;
    logic             unused_low_bits;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    function automatic logic [15:0] cnt_sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign unused_low_bits = ^{pc_i[1:0], ex_pc_i[1:0]};

    // lookup stage: prediction for the instruction currently at pc_i
    assign lk_idx       = pc_i[IDX_W+1:2];
    assign lk_tag       = pc_i[31:IDX_W+2];
    assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken_o = lk_hit && ctr_q[lk_idx][1];
    assign pred_next    = pred_taken_o ? tgt_q[lk_idx] : pc_i + 32'd4;

    // resolution stage: compare the EX outcome with the prediction it carried
    assign ex_idx     = ex_pc_i[IDX_W+1:2];
    assign ex_tag     = ex_pc_i[31:IDX_W+2];
    assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_br      = ex_valid_i && ex_is_branch_i;
    assign actual     = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    // held in reset, the unit presents the plain sequential-fetch outputs
    assign mispredict = rst_i && ex_br && (actual != ex_pred_pc_i);

    always_comb begin
        pc_next_o  = pred_next;
        pc_write_o = 1'b1;
        flush_o    = 1'b0;
        if (mispredict) begin
            pc_next_o = actual;
            flush_o   = 1'b1;
        end else if (stall_i && rst_i) begin
            pc_write_o = 1'b0;
        end
    end

    // update stage: control state (valid, counters, mispredict count)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q       <= '0;
            mispred_cnt_o <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
        end else begin
            if (ex_br) begin
                if (ex_hit) begin
                    ctr_q[ex_idx] <= ex_taken_i ? ctr_inc(ctr_q[ex_idx]) : ctr_dec(ctr_q[ex_idx]);
                end else if (ex_taken_i) begin
                    valid_q[ex_idx] <= 1'b1;
                    ctr_q[ex_idx]   <= 2'b10;
                end
            end
            if (mispredict) mispred_cnt_o <= cnt_sat_inc(mispred_cnt_o);
        end
    end

    // tag/target payload carries no reset; valid_q guards it
    always_ff @(posedge clk_i) begin
        if (ex_br && ex_taken_i) begin
            tag_q[ex_idx] <= ex_tag;
            tgt_q[ex_idx] <= ex_target_i;
        end
    end
endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit; expected values are hand-computed.
module tb_next_pc_unit;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        ex_valid_i, ex_is_branch_i, ex_taken_i;
    logic [31:0] ex_pc_i, ex_target_i, ex_pred_pc_i;
    logic [31:0] pc_next_o;
    logic        pc_write_o, pred_taken_o, flush_o;
    logic [15:0] mispred_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    next_pc_unit #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .stall_i(stall_i),
        .ex_valid_i(ex_valid_i), .ex_is_branch_i(ex_is_branch_i), .ex_taken_i(ex_taken_i),
        .ex_pc_i(ex_pc_i), .ex_target_i(ex_target_i), .ex_pred_pc_i(ex_pred_pc_i),
        .pc_next_o(pc_next_o), .pc_write_o(pc_write_o), .pred_taken_o(pred_taken_o),
        .flush_o(flush_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic no_ex();
        ex_valid_i = 1'b0; ex_is_branch_i = 1'b0; ex_taken_i = 1'b0;
        ex_pc_i = '0; ex_target_i = '0; ex_pred_pc_i = '0;
    endtask

    task automatic ex_branch(input logic [31:0] pc, input logic taken,
                             input logic [31:0] tgt, input logic [31:0] pred);
        ex_valid_i = 1'b1; ex_is_branch_i = 1'b1; ex_taken_i = taken;
        ex_pc_i = pc; ex_target_i = tgt; ex_pred_pc_i = pred;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; stall_i = 1'b0; pc_i = 32'h40; no_ex();
        #2;
        n_chk++; if (pc_next_o !== 32'h44) begin n_fail++; $display("FAIL reset_pc_next: got %h want %h", pc_next_o, 32'h44); end
        n_chk++; if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %b want 0", pred_taken_o); end
        n_chk++; if (pc_write_o !== 1'b1) begin n_fail++; $display("FAIL reset_write: got %b want 1", pc_write_o); end
        n_chk++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", flush_o); end
        n_chk++; if (mispred_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", mispred_cnt_o); end
        tick(); tick();
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_allocate();
        pc_i = 32'h40; ex_branch(32'h40, 1'b1, 32'h100, 32'h44);
        #1;
        n_chk++; if (pc_next_o !== 32'h100) begin n_fail++; $display("FAIL alloc_redirect: got %h want %h", pc_next_o, 32'h100); end
        n_chk++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL alloc_flush: got %b want 1", flush_o); end
        n_chk++; if (mispred_cnt_o !== 16'd0) begin n_fail++; $display("FAIL alloc_cnt_before: got %0d want 0", mispred_cnt_o); end
        tick(); no_ex(); #1;
        n_chk++; if (mispred_cnt_o !== 16'd1) begin n_fail++; $display("FAIL alloc_cnt_after: got %0d want 1", mispred_cnt_o); end
        n_chk++; if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL alloc_pred: got %b want 1", pred_taken_o); end
        n_chk++; if (pc_next_o !== 32'h100) begin n_fail++; $display("FAIL alloc_pc_next: got %h want %h", pc_next_o, 32'h100); end
    endtask

    task automatic test_train();
        // ctr 10 predicted taken; resolves not taken -> mispredict
        ex_branch(32'h40, 1'b0, 32'h100, 32'h100); #1;
        n_chk++; if (pc_next_o !== 32'h44 || flush_o !== 1'b1) begin n_fail++; $display("FAIL train_nt1: got %h/%b want 44/1", pc_next_o, flush_o); end
        tick(); no_ex(); #1;
        n_chk++; if (pred_taken_o !== 1'b0 || pc_next_o !== 32'h44) begin n_fail++; $display("FAIL train_ctr01: got %b/%h want 0/44", pred_taken_o, pc_next_o); end
        n_chk++; if (mispred_cnt_o !== 16'd2) begin n_fail++; $display("FAIL train_cnt: got %0d want 2", mispred_cnt_o); end
        ex_branch(32'h40, 1'b0, 32'h100, 32'h44); #1;
        n_chk++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL train_nt2_flush: got %b want 0", flush_o); end
        tick();
        // ctr 00: another not-taken must stay at 00
        ex_branch(32'h40, 1'b0, 32'h100, 32'h44); tick();
        ex_branch(32'h40, 1'b1, 32'h200, 32'h200); tick();
        no_ex(); #1;
        n_chk++; if (pred_taken_o !== 1'b0 || pc_next_o !== 32'h44) begin n_fail++; $display("FAIL train_floor: got %b/%h want 0/44", pred_taken_o, pc_next_o); end
        ex_branch(32'h40, 1'b1, 32'h200, 32'h200); tick();
        no_ex(); #1;
        n_chk++; if (pred_taken_o !== 1'b1 || pc_next_o !== 32'h200) begin n_fail++; $display("FAIL train_retarget: got %b/%h want 1/200", pred_taken_o, pc_next_o); end
        n_chk++; if (mispred_cnt_o !== 16'd2) begin n_fail++; $display("FAIL train_cnt_hold: got %0d want 2", mispred_cnt_o); end
    endtask

    task automatic test_alias();
        ex_branch(32'h440, 1'b1, 32'h300, 32'h300); tick();
        no_ex(); pc_i = 32'h40; #1;
        n_chk++; if (pred_taken_o !== 1'b0 || pc_next_o !== 32'h44) begin n_fail++; $display("FAIL alias_old: got %b/%h want 0/44", pred_taken_o, pc_next_o); end
        pc_i = 32'h443; #1;
        n_chk++; if (pred_taken_o !== 1'b1 || pc_next_o !== 32'h300) begin n_fail++; $display("FAIL alias_new_lowbits: got %b/%h want 1/300", pred_taken_o, pc_next_o); end
        // miss + not taken leaves the occupant alone
        ex_branch(32'h840, 1'b0, 32'h900, 32'h844); tick();
        no_ex(); pc_i = 32'h440; #1;
        n_chk++; if (pred_taken_o !== 1'b1 || pc_next_o !== 32'h300) begin n_fail++; $display("FAIL alias_miss_nt: got %b/%h want 1/300", pred_taken_o, pc_next_o); end
    endtask

    task automatic test_stall();
        stall_i = 1'b1; pc_i = 32'h80; no_ex(); #1;
        n_chk++; if (pc_write_o !== 1'b0 || pc_next_o !== 32'h84 || flush_o !== 1'b0) begin n_fail++; $display("FAIL stall_plain: got %b/%h/%b want 0/84/0", pc_write_o, pc_next_o, flush_o); end
        ex_branch(32'h80, 1'b1, 32'h500, 32'h84); #1;
        n_chk++; if (pc_write_o !== 1'b1 || flush_o !== 1'b1 || pc_next_o !== 32'h500) begin n_fail++; $display("FAIL stall_redirect: got %b/%b/%h want 1/1/500", pc_write_o, flush_o, pc_next_o); end
        tick(); no_ex(); stall_i = 1'b0; #1;
        n_chk++; if (pred_taken_o !== 1'b1 || pc_next_o !== 32'h500) begin n_fail++; $display("FAIL stall_trained: got %b/%h want 1/500", pred_taken_o, pc_next_o); end
        n_chk++; if (mispred_cnt_o !== 16'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d want 3", mispred_cnt_o); end
    endtask

    task automatic test_same_cycle();
        pc_i = 32'h80; ex_branch(32'h80, 1'b0, 32'h500, 32'h84); #1;
        n_chk++; if (pc_next_o !== 32'h500 || flush_o !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pre: got %h/%b want 500/0", pc_next_o, flush_o); end
        tick(); no_ex(); #1;
        n_chk++; if (pc_next_o !== 32'h84) begin n_fail++; $display("FAIL same_cycle_post: got %h want 84", pc_next_o); end
    endtask

    task automatic test_saturate_and_reset();
        pc_i = 32'hC0; ex_branch(32'hC0, 1'b1, 32'h600, 32'h0);
        for (int i = 0; i < 65531; i++) tick();
        n_chk++; if (mispred_cnt_o !== 16'hFFFE) begin n_fail++; $display("FAIL sat_near: got %h want FFFE", mispred_cnt_o); end
        for (int i = 0; i < 5; i++) tick();
        n_chk++; if (mispred_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want FFFF", mispred_cnt_o); end
        stall_i = 1'b1; rst_i = 1'b0; #1;
        n_chk++; if (mispred_cnt_o !== 16'd0 || flush_o !== 1'b0 || pc_write_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ctrl: got %h/%b/%b want 0/0/1", mispred_cnt_o, flush_o, pc_write_o); end
        n_chk++; if (pred_taken_o !== 1'b0 || pc_next_o !== 32'hC4) begin n_fail++; $display("FAIL midrst_lookup: got %b/%h want 0/C4", pred_taken_o, pc_next_o); end
        no_ex(); stall_i = 1'b0; tick(); rst_i = 1'b1; tick();
        pc_i = 32'h440; #1;
        n_chk++; if (pred_taken_o !== 1'b0 || pc_next_o !== 32'h444) begin n_fail++; $display("FAIL postrst_cleared: got %b/%h want 0/444", pred_taken_o, pc_next_o); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_train();
        test_alias();
        test_stall();
        test_same_cycle();
        test_saturate_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
